// File: rtl/qarma_tk_pkg.sv
// Shared constants and types for the QARMAv2-128 iterative tweakey scheduler.
// Holds the round constants, the reflection constant and the tweak cell permutation.
package qarma_tk_pkg;

   localparam int N     = 128;
   localparam int CELLS = 32;

   typedef logic [N-1:0] word_t;

   // Entry i names the source cell that lands in destination cell i.
   typedef logic [0:CELLS-1][4:0] perm_table_t;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      BWD
   } state_t;

   localparam word_t RC [0:15] = '{
      128'h243F6A88_85A308D3_13198A2E_03707344,
      128'hA4093822_299F31D0_082EFA98_EC4E6C89,
      128'h452821E6_38D01377_BE5466CF_34E90C6C,
      128'hC0AC29B7_C97C50DD_3F84D5B5_B5470917,
      128'h9216D5D9_8979FB1B_D1310BA6_98DFB5AC,
      128'h2FFD72DB_D01ADFB7_B8E1AFED_6A267E96,
      128'hBA7C9045_F12C7F99_24A19947_B3916CF7,
      128'h0801F2E2_858EFC16_636920D8_71574E69,
      128'hA458FEA3_F4933D7E_0D95748F_728EB658,
      128'h718BCD58_82154AEE_7B54A41D_C25A59B5,
      128'h9C30D539_2AF26013_C5D1B023_286085F0,
      128'hCA417918_B8DB38EF_8E79DCB0_603A180E,
      128'h6C9E0E8B_B01E8A3E_D71577C1_BD314B27,
      128'h78AF2FDA_55605C60_E65525F3_AA55AB94,
      128'h57489862_63E81440_55CA396A_2AAB10B6,
      128'hB4CC5C34_1141E8CE_A15486AF_7C72E993
   };

   localparam word_t ALPHA = 128'h3F84D5B5_B5470917_C0AC29B7_C97C50DD;

   localparam perm_table_t TWEAK_PERM = {
      5'd3,  5'd10, 5'd17, 5'd24, 5'd31, 5'd6,  5'd13, 5'd20,
      5'd27, 5'd2,  5'd9,  5'd16, 5'd23, 5'd30, 5'd5,  5'd12,
      5'd19, 5'd26, 5'd1,  5'd8,  5'd15, 5'd22, 5'd29, 5'd4,
      5'd11, 5'd18, 5'd25, 5'd0,  5'd7,  5'd14, 5'd21, 5'd28
   };

   // Builds the gather table that undoes p, so IPERM(PERM(x)) == x.
   function automatic perm_table_t invertPerm(input perm_table_t p);
      perm_table_t q;
      q = '0;
      for (int i = 0; i < CELLS; i++) begin
         q[p[i]] = 5'(i);
      end
      return q;
   endfunction

   localparam perm_table_t TWEAK_IPERM = invertPerm(TWEAK_PERM);

endpackage

// File: rtl/qarma_tk_perm.sv
// Combinational cell-wise tweak permutation; inv selects the inverse table.
module qarma_tk_perm
   import qarma_tk_pkg::*;
(
   input  logic [N-1:0] x,
   input  logic         inv,
   output logic [N-1:0] y
);

   // Each 4-bit destination cell gathers from the cell named in the table.
   always_comb begin
      y = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (inv) begin
            y[4*i +: 4] = x[4*int'(TWEAK_IPERM[i]) +: 4];
         end else begin
            y[4*i +: 4] = x[4*int'(TWEAK_PERM[i]) +: 4];
         end
      end
   end

endmodule

// File: rtl/qarma_tk_sched.sv
// Iterative QARMAv2-128 tweakey scheduler: streams ROUNDS forward then ROUNDS backward tweakeys.
// Optional macro QARMA_TK_ABORT_EN adds an abort input that cancels a running schedule.
module qarma_tk_sched #(
   parameter int ROUNDS = 9,
   parameter int N      = qarma_tk_pkg::N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] key,
   input  logic [N-1:0] tweak,
`ifdef QARMA_TK_ABORT_EN
   input  logic         abort,
`endif
   output logic         busy,
   output logic         tk_valid,
   input  logic         tk_ready,
   output logic [N-1:0] tk,
   output logic [3:0]   round_idx,
   output logic         dir,
   output logic         done
);

   import qarma_tk_pkg::state_t;
   import qarma_tk_pkg::IDLE;
   import qarma_tk_pkg::FWD;
   import qarma_tk_pkg::BWD;
   import qarma_tk_pkg::RC;
   import qarma_tk_pkg::ALPHA;

   localparam logic [3:0] LAST = 4'(ROUNDS - 1);

   state_t       state;
   logic [N-1:0] k;
   logic [N-1:0] t;
   logic [N-1:0] tStep;
   logic [3:0]   r;
   logic         accept;
   logic         abortReq;

   assign accept = tk_valid & tk_ready;

`ifdef QARMA_TK_ABORT_EN
   assign abortReq = abort;
`else
   assign abortReq = 1'b0;
`endif

   // One shared permutation unit: forward rounds permute, backward rounds undo it.
   qarma_tk_perm perm (
      .x   (t),
      .inv (state == BWD),
      .y   (tStep)
   );

   // tk is computed from the next-state values so it is registered with round_idx and dir.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         k         <= '0;
         t         <= '0;
         r         <= '0;
         tk_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dir       <= 1'b0;
         round_idx <= '0;
         tk        <= '0;
      end else begin
         done <= 1'b0;
         if (abortReq && state != IDLE) begin
            state    <= IDLE;
            k        <= '0;
            t        <= '0;
            tk_valid <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     k         <= key;
                     t         <= tweak;
                     r         <= '0;
                     state     <= FWD;
                     busy      <= 1'b1;
                     tk_valid  <= 1'b1;
                     dir       <= 1'b0;
                     round_idx <= '0;
                     tk        <= key ^ tweak ^ RC[0];
                  end
               end
               FWD: begin
                  if (accept) begin
                     if (r != LAST) begin
                        t         <= tStep;
                        r         <= r + 4'd1;
                        round_idx <= r + 4'd1;
                        tk        <= k ^ tStep ^ RC[r + 4'd1];
                     end else begin
                        state <= BWD;
                        dir   <= 1'b1;
                        tk    <= k ^ ALPHA ^ t ^ RC[r];
                     end
                  end
               end
               BWD: begin
                  if (accept) begin
                     if (r != 4'd0) begin
                        t         <= tStep;
                        r         <= r - 4'd1;
                        round_idx <= r - 4'd1;
                        tk        <= k ^ ALPHA ^ tStep ^ RC[r - 4'd1];
                     end else begin
                        state    <= IDLE;
                        tk_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qarma_tk_sched.sv
// Scoreboard bench for qarma_tk_sched; define QARMA_TK_ABORT_EN to also cover abort.
`timescale 1ns/1ps
module tb_qarma_tk_sched;
   import qarma_tk_pkg::*;

   localparam int ROUNDS = 9;
   localparam int TOTAL  = 2 * ROUNDS;

   typedef struct packed {
      logic [N-1:0] tk;
      logic [3:0]   idx;
      logic         dir;
   } exp_t;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b1;
   logic         start    = 1'b0;
   logic         tk_ready = 1'b0;
   logic [N-1:0] key      = '0;
   logic [N-1:0] tweak    = '0;
`ifdef QARMA_TK_ABORT_EN
   logic         abort    = 1'b0;
`endif
   logic         busy;
   logic         tk_valid;
   logic [N-1:0] tk;
   logic [3:0]   round_idx;
   logic         dir;
   logic         done;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   qarma_tk_sched #(.ROUNDS(ROUNDS), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key       (key),
      .tweak     (tweak),
`ifdef QARMA_TK_ABORT_EN
      .abort     (abort),
`endif
      .busy      (busy),
      .tk_valid  (tk_valid),
      .tk_ready  (tk_ready),
      .tk        (tk),
      .round_idx (round_idx),
      .dir       (dir),
      .done      (done)
   );

   function automatic logic [N-1:0] modelPerm(input logic [N-1:0] x);
      logic [N-1:0] y = '0;
      for (int i = 0; i < CELLS; i++) y[4*i +: 4] = x[4*int'(TWEAK_PERM[i]) +: 4];
      return y;
   endfunction

   function automatic logic [N-1:0] modelIperm(input logic [N-1:0] x);
      logic [N-1:0] y = '0;
      for (int i = 0; i < CELLS; i++) y[4*int'(TWEAK_PERM[i]) +: 4] = x[4*i +: 4];
      return y;
   endfunction

   task automatic pushSchedule(input logic [N-1:0] kk, input logic [N-1:0] tt);
      logic [N-1:0] tr = tt;
      for (int r = 0; r < ROUNDS; r++) begin
         expQ.push_back('{kk ^ tr ^ RC[r], 4'(r), 1'b0});
         if (r < ROUNDS - 1) tr = modelPerm(tr);
      end
      for (int r = ROUNDS - 1; r >= 0; r--) begin
         expQ.push_back('{kk ^ ALPHA ^ tr ^ RC[r], 4'(r), 1'b1});
         if (r > 0) tr = modelIperm(tr);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic rdy);
      @(posedge clk);
      #1;
      start    = s;
      tk_ready = rdy;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #2;
      checks++;
      if ({busy, tk_valid, done, dir, round_idx, tk} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%b valid=%b done=%b dir=%b idx=%0d tk=%h, want all 0",
                  busy, tk_valid, done, dir, round_idx, tk);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b0, 1'b1);
         checks++;
         if ({busy, tk_valid, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b valid=%b done=%b, want 000", busy, tk_valid, done);
         end
      end
   endtask

   task automatic test_basic();
      exp_t e;
      key   = '0;
      tweak = '0;
      pushSchedule(key, tweak);
      applyStimulus(1'b1, 1'b1);
      checks++;
      if (tk_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_latency: tk_valid=%b in start cycle, want 0", tk_valid);
      end
      for (int cyc = 1; cyc <= 19; cyc++) begin
         applyStimulus(1'b0, 1'b1);
         if (cyc <= TOTAL) begin
            checks++;
            if ({tk_valid, busy} !== 2'b11) begin
               errors++;
               $display("[TB] FAIL basic_valid: cycle %0d valid=%b busy=%b, want 11", cyc, tk_valid, busy);
            end
         end
         if (tk_valid && tk_ready) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL basic_extra: unexpected tk=%h, want none", tk);
            end else begin
               e = expQ.pop_front();
               if ({tk, round_idx, dir} !== e) begin
                  errors++;
                  $display("[TB] FAIL basic_tk: got tk=%h idx=%0d dir=%b, want tk=%h idx=%0d dir=%b",
                           tk, round_idx, dir, e.tk, e.idx, e.dir);
               end
            end
         end
         checks++;
         if (done !== (cyc == 19)) begin
            errors++;
            $display("[TB] FAIL basic_done: cycle %0d done=%b, want %b", cyc, done, cyc == 19);
         end
      end
      checks++;
      if ({busy, tk_valid} !== 2'b00 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL basic_end: busy=%b valid=%b left=%0d, want 00 and 0", busy, tk_valid, expQ.size());
      end
      expQ.delete();
   endtask

   task automatic test_stall();
      exp_t         e;
      int           accepts = 0;
      bit           doneSeen = 0;
      bit           prevStall = 0;
      logic [N+4:0] held = '0;
      key   = '1;
      tweak = '0;
      pushSchedule(key, tweak);
      applyStimulus(1'b1, 1'b1);
      for (int cyc = 1; cyc <= 60 && !doneSeen; cyc++) begin
         applyStimulus(1'b0, cyc[0]);
         if (prevStall) begin
            checks++;
            if ({tk, round_idx, dir} !== held || tk_valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL stall_hold: got tk=%h idx=%0d dir=%b valid=%b, want held %h",
                        tk, round_idx, dir, tk_valid, held);
            end
         end
         if (tk_valid && tk_ready) begin
            accepts++;
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL stall_extra: unexpected tk=%h, want none", tk);
            end else begin
               e = expQ.pop_front();
               if ({tk, round_idx, dir} !== e) begin
                  errors++;
                  $display("[TB] FAIL stall_tk: got tk=%h idx=%0d dir=%b, want tk=%h idx=%0d dir=%b",
                           tk, round_idx, dir, e.tk, e.idx, e.dir);
               end
            end
            if (dir == 1'b0) begin
               checks++;
               if (tk !== ~RC[round_idx]) begin
                  errors++;
                  $display("[TB] FAIL stall_fwd_not_rc: got tk=%h, want %h", tk, ~RC[round_idx]);
               end
            end
         end
         prevStall = tk_valid && !tk_ready;
         held      = {tk, round_idx, dir};
         if (done) doneSeen = 1;
      end
      checks++;
      if (accepts != TOTAL || !doneSeen) begin
         errors++;
         $display("[TB] FAIL stall_count: accepts=%0d done_seen=%0d, want %0d and 1", accepts, doneSeen, TOTAL);
      end
      expQ.delete();
   endtask

   task automatic test_random_tweak();
      exp_t         e;
      logic [N-1:0] kt [0:15];
      logic [N-1:0] tr;
      bit           doneSeen = 0;
      key   = {$urandom, $urandom, $urandom, $urandom};
      tweak = {$urandom, $urandom, $urandom, $urandom};
      tr    = tweak;
      for (int r = 0; r < 16; r++) kt[r] = '0;
      for (int r = 0; r < ROUNDS; r++) begin
         kt[r] = key ^ tr;
         tr    = modelPerm(tr);
      end
      pushSchedule(key, tweak);
      applyStimulus(1'b1, 1'b1);
      for (int cyc = 1; cyc <= 30 && !doneSeen; cyc++) begin
         applyStimulus(1'b0, 1'b1);
         if (tk_valid && tk_ready) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL rand_extra: unexpected tk=%h, want none", tk);
            end else begin
               e = expQ.pop_front();
               if ({tk, round_idx, dir} !== e) begin
                  errors++;
                  $display("[TB] FAIL rand_tk: got tk=%h idx=%0d dir=%b, want tk=%h idx=%0d dir=%b",
                           tk, round_idx, dir, e.tk, e.idx, e.dir);
               end
            end
            checks++;
            if ((tk ^ RC[round_idx] ^ (dir ? ALPHA : '0)) !== kt[round_idx]) begin
               errors++;
               $display("[TB] FAIL rand_kt_recover: r=%0d dir=%b got %h, want %h",
                        round_idx, dir, tk ^ RC[round_idx] ^ (dir ? ALPHA : '0), kt[round_idx]);
            end
         end
         if (done) doneSeen = 1;
      end
      checks++;
      if (!doneSeen) begin
         errors++;
         $display("[TB] FAIL rand_timeout: done=0 after 30 cycles, want 1");
      end
      expQ.delete();
   endtask

   task automatic test_start_ignored();
      exp_t         e;
      int           dones = 0;
      bit           restartPending = 0;
      logic [N-1:0] key3 = {$urandom, $urandom, $urandom, $urandom};
      logic [N-1:0] tweak3 = {$urandom, $urandom, $urandom, $urandom};
      key   = {4{32'h1357_9BDF}};
      tweak = {4{32'h0246_8ACE}};
      pushSchedule(key, tweak);
      applyStimulus(1'b1, 1'b1);
      for (int cyc = 1; cyc <= 60 && dones < 2; cyc++) begin
         applyStimulus(1'b0, 1'b1);
         if (restartPending) begin
            restartPending = 0;
            checks++;
            if ({tk_valid, busy} !== 2'b11) begin
               errors++;
               $display("[TB] FAIL restart_valid: valid=%b busy=%b after done-cycle start, want 11", tk_valid, busy);
            end
         end
         if (tk_valid && tk_ready) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL ignore_extra: unexpected tk=%h, want none", tk);
            end else begin
               e = expQ.pop_front();
               if ({tk, round_idx, dir} !== e) begin
                  errors++;
                  $display("[TB] FAIL ignore_tk: got tk=%h idx=%0d dir=%b, want tk=%h idx=%0d dir=%b",
                           tk, round_idx, dir, e.tk, e.idx, e.dir);
               end
            end
         end
         if (cyc == 5) begin
            start = 1'b1;
            key   = ~key;
            tweak = ~tweak;
         end
         if (done) begin
            dones++;
            if (dones == 1) begin
               start = 1'b1;
               key   = key3;
               tweak = tweak3;
               pushSchedule(key3, tweak3);
               restartPending = 1;
            end
         end
      end
      checks++;
      if (dones != 2 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL ignore_end: dones=%0d left=%0d, want 2 and 0", dones, expQ.size());
      end
      expQ.delete();
   endtask

   task automatic test_async_reset();
      bit reached = 0;
      key   = {$urandom, $urandom, $urandom, $urandom};
      tweak = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 1'b1);
      for (int cyc = 1; cyc <= 20 && !reached; cyc++) begin
         applyStimulus(1'b0, 1'b1);
         if (tk_valid && dir && round_idx == 4'd5) reached = 1;
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("[TB] FAIL areset_reach: backward round 5 not seen, want seen");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, tk_valid, done, dir, round_idx, tk} !== '0) begin
         errors++;
         $display("[TB] FAIL areset_outputs: got busy=%b valid=%b done=%b dir=%b idx=%0d tk=%h, want all 0",
                  busy, tk_valid, done, dir, round_idx, tk);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b1);
         checks++;
         if ({busy, tk_valid, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL areset_idle: got busy=%b valid=%b done=%b, want 000", busy, tk_valid, done);
         end
      end
   endtask

`ifdef QARMA_TK_ABORT_EN
   task automatic test_abort();
      exp_t e;
      bit   hit = 0;
      int   accepts = 0;
      bit   doneSeen = 0;
      key   = {$urandom, $urandom, $urandom, $urandom};
      tweak = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 1'b1);
      for (int cyc = 1; cyc <= 10 && !hit; cyc++) begin
         applyStimulus(1'b0, 1'b1);
         if (tk_valid && !dir && round_idx == 4'd4) hit = 1;
      end
      abort = 1'b1;
      applyStimulus(1'b0, 1'b1);
      abort = 1'b0;
      checks++;
      if (!hit || {tk_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL abort_idle: hit=%0d valid=%b busy=%b done=%b, want 1 and 000", hit, tk_valid, busy, done);
      end
      applyStimulus(1'b0, 1'b1);
      checks++;
      if ({tk_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL abort_no_done: valid=%b busy=%b done=%b, want 000", tk_valid, busy, done);
      end
      pushSchedule(key, tweak);
      applyStimulus(1'b1, 1'b1);
      for (int cyc = 1; cyc <= 30 && !doneSeen; cyc++) begin
         applyStimulus(1'b0, 1'b1);
         if (tk_valid && tk_ready) begin
            accepts++;
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL abort_extra: unexpected tk=%h, want none", tk);
            end else begin
               e = expQ.pop_front();
               if ({tk, round_idx, dir} !== e) begin
                  errors++;
                  $display("[TB] FAIL abort_restart_tk: got tk=%h idx=%0d dir=%b, want tk=%h idx=%0d dir=%b",
                           tk, round_idx, dir, e.tk, e.idx, e.dir);
               end
            end
         end
         if (done) doneSeen = 1;
      end
      checks++;
      if (accepts != TOTAL || !doneSeen) begin
         errors++;
         $display("[TB] FAIL abort_restart_count: accepts=%0d done_seen=%0d, want %0d and 1", accepts, doneSeen, TOTAL);
      end
      expQ.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random_tweak();
      test_start_ignored();
      test_async_reset();
`ifdef QARMA_TK_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
